// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with bubble insertion, hold watchdog and
// optional performance counters (enabled by defining PIPE_STAGE_PERF_EN).
module pipe_stage_reg #(
  parameter int unsigned        DATA_W   = 128,
  parameter int unsigned        KEEP_W   = 44,
  parameter logic [DATA_W-1:0]  DATA_NOP = '0,
  parameter logic [KEEP_W-1:0]  KEEP_RST = KEEP_W'(44'h10),
  parameter int unsigned        STALL_W  = 4,
  parameter int unsigned        STAGE    = 2,
  parameter int unsigned        HOLD_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [STALL_W-1:0] stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  output logic              out_valid,
  output logic              out_bubble,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic [7:0]        hold_cnt,
  output logic              hold_timeout,
  output logic [15:0]       perf_stall_cycles,
  output logic [15:0]       perf_bubbles
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  logic              r_valid;
  logic              r_bubble;
  logic [DATA_W-1:0] r_data;
  logic [KEEP_W-1:0] r_keep;
  logic [CNT_W-1:0]  r_hold_cnt;
  logic              r_hold_timeout;

  logic              w_s_here;
  logic              w_s_down;
  logic              w_bubble;
  logic              w_hold;
  logic              w_advance;
  logic              w_valid_nxt;
  logic              w_bubble_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic [KEEP_W-1:0] w_keep_nxt;
  logic [CNT_W-1:0]  w_hold_nxt;

  assign w_s_here = stall[STAGE];

  // The last stage has no downstream stall bit.
  if (STAGE + 1 < STALL_W) begin : g_down
    assign w_s_down = stall[STAGE+1];
  end else begin : g_no_down
    assign w_s_down = 1'b0;
  end

  assign w_bubble  = !flush &&  w_s_here && !w_s_down;
  assign w_hold    = !flush &&  w_s_here &&  w_s_down;
  assign w_advance = !flush && !w_s_here;

  // Next-state selection in priority order: flush, bubble, hold, advance.
  always_comb begin
    w_valid_nxt  = r_valid;
    w_bubble_nxt = r_bubble;
    w_data_nxt   = r_data;
    w_keep_nxt   = r_keep;
    w_hold_nxt   = '0;
    if (flush) begin
      w_valid_nxt  = 1'b0;
      w_bubble_nxt = 1'b0;
      w_data_nxt   = '0;
      w_keep_nxt   = KEEP_RST;
    end else if (w_bubble) begin
      w_valid_nxt  = 1'b0;
      w_bubble_nxt = 1'b1;
      w_data_nxt   = DATA_NOP;
      w_keep_nxt   = in_keep;
    end else if (w_hold) begin
      w_hold_nxt = (r_hold_cnt == CNT_MAX) ? r_hold_cnt : r_hold_cnt + CNT_W'(1);
    end else if (w_advance) begin
      w_valid_nxt  = in_valid;
      w_bubble_nxt = 1'b0;
      w_data_nxt   = in_data;
      w_keep_nxt   = in_keep;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid        <= 1'b0;
      r_bubble       <= 1'b0;
      r_data         <= '0;
      r_keep         <= KEEP_RST;
      r_hold_cnt     <= '0;
      r_hold_timeout <= 1'b0;
    end else begin
      r_valid        <= w_valid_nxt;
      r_bubble       <= w_bubble_nxt;
      r_data         <= w_data_nxt;
      r_keep         <= w_keep_nxt;
      r_hold_cnt     <= w_hold_nxt;
      r_hold_timeout <= (w_hold_nxt >= HOLD_LIM);
    end
  end

  assign out_valid    = r_valid;
  assign out_bubble   = r_bubble;
  assign out_data     = r_data;
  assign out_keep     = r_keep;
  assign hold_cnt     = r_hold_cnt;
  assign hold_timeout = r_hold_timeout;

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] r_perf_stall;
  logic [15:0] r_perf_bub;

  // Saturating counters; flush deliberately leaves them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_bub   <= '0;
    end else begin
      if ((w_hold || w_bubble) && (r_perf_stall != 16'hFFFF)) begin
        r_perf_stall <= r_perf_stall + 16'd1;
      end
      if (w_bubble && (r_perf_bub != 16'hFFFF)) begin
        r_perf_bub <= r_perf_bub + 16'd1;
      end
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_bubbles      = r_perf_bub;
`else
  assign perf_stall_cycles = '0;
  assign perf_bubbles      = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: stimulus queues expected register contents,
// a monitor pops and compares one entry after each clock edge.
module tb_pipe_stage_reg;

  typedef struct {
    logic         valid;
    logic         bubble;
    logic [127:0] data;
    logic [43:0]  keep;
    logic [7:0]   hc;
    logic         to;
    logic [15:0]  ps;
    logic [15:0]  pb;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   stall;
  logic         flush;
  logic         in_valid;
  logic [127:0] in_data;
  logic [43:0]  in_keep;
  logic         out_valid;
  logic         out_bubble;
  logic [127:0] out_data;
  logic [43:0]  out_keep;
  logic [7:0]   hold_cnt;
  logic         hold_timeout;
  logic [15:0]  perf_stall_cycles;
  logic [15:0]  perf_bubbles;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   eps = 0;
  int   epb = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_keep(in_keep),
    .out_valid(out_valid), .out_bubble(out_bubble), .out_data(out_data),
    .out_keep(out_keep), .hold_cnt(hold_cnt), .hold_timeout(hold_timeout),
    .perf_stall_cycles(perf_stall_cycles), .perf_bubbles(perf_bubbles)
  );

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_all(input exp_t e);
    cmp("out_valid", 128'(out_valid), 128'(e.valid));
    cmp("out_bubble", 128'(out_bubble), 128'(e.bubble));
    cmp("out_data", out_data, e.data);
    cmp("out_keep", 128'(out_keep), 128'(e.keep));
    cmp("hold_cnt", 128'(hold_cnt), 128'(e.hc));
    cmp("hold_timeout", 128'(hold_timeout), 128'(e.to));
    cmp("perf_stall_cycles", 128'(perf_stall_cycles), 128'(e.ps));
    cmp("perf_bubbles", 128'(perf_bubbles), 128'(e.pb));
  endtask

  function automatic exp_t mk(input logic v, input logic b, input logic [127:0] d,
                              input logic [43:0] k, input int hc);
    exp_t e;
    e.valid  = v;
    e.bubble = b;
    e.data   = d;
    e.keep   = k;
    e.hc     = 8'(hc);
    e.to     = (hc >= 15);
`ifdef PIPE_STAGE_PERF_EN
    e.ps = 16'(eps);
    e.pb = 16'(epb);
`else
    e.ps = 16'h0;
    e.pb = 16'h0;
`endif
    return e;
  endfunction

  // Drive one edge's inputs and queue the register contents expected after it.
  task automatic step(input logic [3:0] st, input logic fl, input logic v,
                      input logic [127:0] d, input logic [43:0] k, input exp_t e);
    @(negedge clk);
    stall    = st;
    flush    = fl;
    in_valid = v;
    in_data  = d;
    in_keep  = k;
    exp_q.push_back(e);
  endtask

  // Monitor: one comparison set per clock edge that has a queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check_all(exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; stall = '0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; in_keep = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    step(4'b0000, 0, 1, 128'hA5, 44'h123, mk(1, 0, 128'hA5, 44'h123, 0));
    step(4'b0000, 0, 0, 128'h77, 44'h9, mk(0, 0, 128'h77, 44'h9, 0));
    step(4'b0000, 0, 1, 128'hDEADBEEF, 44'hABC, mk(1, 0, 128'hDEADBEEF, 44'hABC, 0));
    for (int i = 1; i <= 2; i++) begin
      eps++;
      step(4'b1100, 0, 1, 128'h1000 + 128'(i), 44'h200 + 44'(i),
           mk(1, 0, 128'hDEADBEEF, 44'hABC, i));
    end
    for (int j = 0; j < 3; j++) begin
      eps++; epb++;
      step(4'b0100, 0, 1, 128'hFFFF, 44'h456 + 44'(j), mk(0, 1, 128'h0, 44'h456 + 44'(j), 0));
    end
    // Flush beats a full stall; perf counters survive it.
    step(4'b1100, 1, 1, 128'h1234, 44'h999, mk(0, 0, 128'h0, 44'h10, 0));
    for (int i = 1; i <= 16; i++) begin
      eps++;
      step(4'b1100, 0, 1, 128'h55, 44'h66, mk(0, 0, 128'h0, 44'h10, i));
    end
    step(4'b0000, 0, 1, 128'h11, 44'h22, mk(1, 0, 128'h11, 44'h22, 0));
    for (int i = 1; i <= 258; i++) begin
      eps++;
      step(4'b1100, 0, 0, 128'h99, 44'h88, mk(1, 0, 128'h11, 44'h22, (i > 255) ? 255 : i));
    end
    step(4'b1100, 1, 1, 128'h1, 44'h2, mk(0, 0, 128'h0, 44'h10, 0));
    eps++; epb++;
    step(4'b0100, 0, 1, 128'h3, 44'h321, mk(0, 1, 128'h0, 44'h321, 0));

    // Asynchronous reset in the middle of a stalled cycle.
    @(negedge clk);
    stall = 4'b0100;
    #2 rst_n = 1'b0;
    #1;
    eps = 0; epb = 0;
    check_all(mk(0, 0, 128'h0, 44'h10, 0));
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0000, 0, 1, 128'hCAFE, 44'hABCD, mk(1, 0, 128'hCAFE, 44'hABCD, 0));

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
